// File: rtl/sv_bus_arbiter.sv
// Slot-based owner arbiter for the shared system bus (CPU / video DMA / audio fetch).
// Define SV_ARB_STATS_EN to build the stolen-slot counter on stall_cnt; otherwise it reads 0.
module sv_bus_arbiter #(
  parameter int DMA_MAX_BURST = 16,
  parameter int BURST_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_dout,
  input  logic        dma_we,
  output logic        dma_gnt,
  input  logic        lcd_block,
  input  logic        aud_req,
  input  logic [15:0] aud_addr,
  output logic        aud_gnt,
  output logic        aud_strobe,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  output logic [1:0]  owner,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_CPU = 2'd0,
    ST_DMA = 2'd1,
    ST_AUD = 2'd2
  } state_t;

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DMA_MAX_BURST);

  state_t             state;
  state_t             state_next;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CPU;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
    end
  end

  // DMA eligibility uses the count after the ending slot is accounted for,
  // so a full burst is exactly DMA_MAX_BURST slots long.
  always_comb begin
    burst_next = burst_cnt;
    state_next = state;
    if (bus_ce) begin
      case (state)
        ST_DMA: if (burst_cnt < BURST_MAX) burst_next = burst_cnt + BURST_W'(1);
        ST_CPU: burst_next = '0;
        default: burst_next = burst_cnt;
      endcase

      if (aud_req && (state != ST_AUD))
        state_next = ST_AUD;
      else if (dma_req && !lcd_block && (burst_next < BURST_MAX))
        state_next = ST_DMA;
      else
        state_next = ST_CPU;
    end
  end

  assign owner      = state;
  assign cpu_rdy    = (state == ST_CPU);
  assign dma_gnt    = (state == ST_DMA);
  assign aud_gnt    = (state == ST_AUD);
  assign aud_strobe = bus_ce && (state == ST_AUD);

  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_we   = cpu_we;
    case (state)
      ST_DMA: begin
        bus_addr = dma_addr;
        bus_dout = dma_dout;
        bus_we   = dma_we;
      end
      ST_AUD: begin
        bus_addr = aud_addr;
        bus_dout = 8'h00;
        bus_we   = 1'b0;
      end
      default: begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
      end
    endcase
  end

`ifdef SV_ARB_STATS_EN
  logic [15:0] stall_q;

  // Counts every slot taken away from the CPU, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= 16'h0000;
    else if (bus_ce && (state != ST_CPU) && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/sv_bus_arbiter.md
Name: sv_bus_arbiter

Overview:
- Slot-based arbiter for the shared system bus (WRAM, VRAM, ROM, I/O), which has three masters: the 65C02 CPU, the video/memory DMA engine and the audio sample-fetch DMA.
- Picks one owner per bus slot and muxes that owner's address, write data and write enable onto the bus.
- Stalls the CPU through RDY while another master owns the bus.
- Sits between the masters and the address decode / memory instances in the top level.

Parameters:
- DMA_MAX_BURST, 16: maximum consecutive DMA-owned slots before one CPU slot is forced; legal range 1..255.
- BURST_W, 8: width of the DMA burst counter; must hold DMA_MAX_BURST.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_ce  in  1  slot strobe: a bus slot ends on each cycle where this is high.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_rdy  out  1  high when the CPU owns the current slot.
- dma_req  in  1  DMA requests the bus; level signal, held for the whole burst.
- dma_addr  in  16  DMA address.
- dma_dout  in  8  DMA write data.
- dma_we  in  1  DMA write enable.
- dma_gnt  out  1  high when DMA owns the current slot.
- lcd_block  in  1  high while the LCD is fetching; DMA must not be granted.
- aud_req  in  1  audio fetch request for a single read.
- aud_addr  in  16  audio fetch address.
- aud_gnt  out  1  high when audio owns the current slot.
- aud_strobe  out  1  one-cycle pulse on the bus_ce that ends an audio slot; audio latches the shared read data on this pulse.
- bus_addr  out  16  muxed address.
- bus_dout  out  8  muxed write data.
- bus_we  out  1  muxed write enable; always 0 during an audio slot.
- owner  out  2  current owner: 0=CPU, 1=DMA, 2=AUD.
- stall_cnt  out  16  stolen-slot counter (see Optional Feature).

Behaviour:
- Owner state: one-hot-equivalent state CPU / DMA / AUD, held in a register.
- The owner changes only on cycles with bus_ce=1. Between strobes the owner and all grants are stable.
- Arbitration at each bus_ce picks the owner of the next slot, highest priority first:
  1. AUD, if aud_req=1 and the ending slot was not an AUD slot. The request is not re-sampled on the strobe that ends its own slot, which prevents a double grant.
  2. DMA, if dma_req=1, lcd_block=0 and burst_cnt < DMA_MAX_BURST.
  3. CPU otherwise. The CPU is the default owner and never requests.
- burst_cnt:
  - Increments at each bus_ce that ends a DMA slot.
  - Clears at each bus_ce that ends a CPU slot.
  - Unchanged across AUD slots, so audio interleaving does not reset fairness.
  - Saturates at DMA_MAX_BURST. At the limit, exactly one CPU slot is forced, then the counter clears and DMA is eligible again.
- Outputs:
  - cpu_rdy, dma_gnt, aud_gnt and owner are decoded directly from the registered state, with no extra latency.
  - bus_addr, bus_dout and bus_we are a combinational mux on the registered state.
  - During an AUD slot: bus_addr=aud_addr, bus_dout=0, bus_we=0.
- aud_strobe = bus_ce AND (state==AUD). The audio requester must drop or renew aud_req after the strobe.
- dma_req falling mid-slot: the slot completes (dma_gnt held until bus_ce), then normal arbitration.
- lcd_block rising mid-DMA-slot: the current slot completes; the next slot goes to AUD or CPU.
- Requests change only the next owner, never the current one.
- Reset:
  - state=CPU, burst_cnt=0, stall_cnt=0.
  - cpu_rdy=1, dma_gnt=0, aud_gnt=0, aud_strobe=0, owner=0.
  - bus_* follow the CPU inputs.
  - Reset asserted mid-burst returns to CPU on the next clk edge, regardless of bus_ce.

Optional Feature:
- Macro: SV_ARB_STATS_EN.
- Defined:
  - stall_cnt increments by 1 at each bus_ce that ends a non-CPU slot.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Not defined: stall_cnt is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset then idle, bus_ce every 4 clks, no requests -> owner=0 and cpu_rdy=1 continuously; bus_addr tracks cpu_addr=16'h1234.
- dma_req held with DMA_MAX_BURST=16, lcd_block=0 -> 16 DMA slots, then 1 CPU slot (cpu_rdy=1 for exactly one slot), then 16 DMA slots again; bus_we follows dma_we.
- aud_req and dma_req rise together -> AUD slot first, aud_strobe pulses once, then DMA; aud_req held high still yields no back-to-back AUD slots; burst_cnt is unchanged across the AUD slot.
- DMA burst with lcd_block=1 asserted for 3 slots mid-burst -> CPU owns those 3 slots; DMA resumes after lcd_block falls; burst_cnt is cleared by the CPU slots.
- reset pulsed for 1 clk mid-DMA-burst, between strobes -> next cycle owner=0, dma_gnt=0, burst_cnt=0; with SV_ARB_STATS_EN, stall_cnt=0.
- SV_ARB_STATS_EN with 10 DMA slots and 2 AUD slots -> stall_cnt=12; without the macro, stall_cnt=0.
